encoder_decoder: RTL and testbench

Rate-1/2, K=7 convolutional encoder (IEEE 802.11a generators g0=133₈, g1=171₈) chained to a hard-decision Viterbi decoder. This is the channel-coding loopback block of the PHY. The encoder output feeds the decoder directly, so the decoded stream reproduces the input stream delayed by the traceback depth. It is used as the coding core and as a self-check of the decoder.

---
 rtl/coding_pkg.sv | 42 ++++
 rtl/decoder.sv | 138 +++++++++++++
 rtl/encoder.sv | 33 +++
 rtl/encoder_decoder.sv | 31 +++
 tb/tb_encoder_decoder.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/coding_pkg.sv
// Shared constants, types and the K=7 rate-1/2 code generator function
// for the channel-coding loopback (802.11a generators 133/171 octal).
package coding_pkg;

    localparam int unsigned K       = 7;
    localparam int unsigned SW      = K - 1;
    localparam int unsigned NSTATES = 64;
    localparam int unsigned D       = 32;
    localparam int unsigned PM_W    = 8;
    localparam int unsigned CNT_W   = $clog2(D + 1);
    localparam int unsigned IDX_W   = $clog2(D);

    localparam logic [K-1:0] G0 = 7'o133;
    localparam logic [K-1:0] G1 = 7'o171;

    typedef logic [PM_W-1:0] pm_t;
    typedef logic [D-1:0]    path_t;

    localparam pm_t PM_MAX  = '1;
    localparam pm_t PM_INIT = PM_W'(NSTATES);

    // Coded pair {A,B} for an input bit entering a given shift-register state.
    function automatic logic [1:0] conv_out(input logic in_bit, input logic [SW-1:0] state);
        logic [K-1:0] taps;
        taps[K-1] = in_bit;
        for (int i = 0; i < int'(SW); i++) begin
            taps[int'(SW) - 1 - i] = state[i];
        end
        return {^(taps & G0), ^(taps & G1)};
    endfunction

    function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
        return 2'(a[1] ^ b[1]) + 2'(a[0] ^ b[0]);
    endfunction

    function automatic pm_t sat_add(input pm_t pm, input logic [1:0] bm);
        logic [PM_W:0] sum;
        sum = {1'b0, pm} + (PM_W + 1)'(bm);
        return (sum > {1'b0, PM_MAX}) ? PM_MAX : sum[PM_W-1:0];
    endfunction

endpackage

// File: rtl/decoder.sv
// Hard-decision register-exchange Viterbi decoder for the K=7 code, with
// fixed-depth steady-state output and an end-of-stream flush.
module decoder
    import coding_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] x,
    input  logic       run,
    output logic       x_decoded,
    output logic       valid
);

    pm_t   pm_q   [NSTATES];
    pm_t   pm_d   [NSTATES];
    pm_t   pm_raw [NSTATES];
    path_t path_q [NSTATES];
    path_t path_d [NSTATES];
    path_t path_acs [NSTATES];

    pm_t           pm_min, best_pm;
    logic [SW-1:0] best_idx;
    path_t         best_path, flush_src;
    logic [IDX_W-1:0] flush_idx;

    logic [CNT_W-1:0] pend_q, pend_d;
    logic             flushing_q, flushing_d;
    path_t            flush_path_q, flush_path_d;
    logic             x_dec_q, x_dec_d;
    logic             valid_q, valid_d;

    // Add-compare-select per state; predecessor {b, n[5:1]}, input bit n[0].
    for (genvar n = 0; n < int'(NSTATES); n++) begin : g_acs
        localparam logic [SW-1:0] P0     = SW'(n / 2);
        localparam logic [SW-1:0] P1     = SW'(n / 2 + int'(NSTATES) / 2);
        localparam logic          IN_BIT = 1'(n % 2);
        localparam logic [1:0]    E0     = conv_out(IN_BIT, P0);
        localparam logic [1:0]    E1     = conv_out(IN_BIT, P1);

        pm_t cand0, cand1;

        always_comb begin
            cand0 = sat_add(pm_q[P0], hamming(x, E0));
            cand1 = sat_add(pm_q[P1], hamming(x, E1));
            if (cand1 < cand0) begin
                pm_raw[n]   = cand1;
                path_acs[n] = {path_q[P1][D-2:0], IN_BIT};
            end else begin
                pm_raw[n]   = cand0;
                path_acs[n] = {path_q[P0][D-2:0], IN_BIT};
            end
        end
    end

    // Normalisation minimum of the new metrics and best current state.
    always_comb begin
        pm_min = pm_raw[0];
        for (int i = 1; i < int'(NSTATES); i++) begin
            if (pm_raw[i] < pm_min) pm_min = pm_raw[i];
        end
        best_pm  = pm_q[0];
        best_idx = '0;
        for (int i = 1; i < int'(NSTATES); i++) begin
            if (pm_q[i] < best_pm) begin
                best_pm  = pm_q[i];
                best_idx = SW'(i);
            end
        end
        best_path = path_q[best_idx];
    end

    always_comb begin
        for (int i = 0; i < int'(NSTATES); i++) begin
            pm_d[i]   = pm_q[i];
            path_d[i] = path_q[i];
            if (run) begin
                pm_d[i]   = pm_raw[i] - pm_min;
                path_d[i] = path_acs[i];
            end
        end
    end

    // Output scheduling: steady-state emission, flush, and flush abort.
    always_comb begin
        pend_d       = pend_q;
        flushing_d   = flushing_q;
        flush_path_d = flush_path_q;
        x_dec_d      = 1'b0;
        valid_d      = 1'b0;
        flush_src    = flushing_q ? flush_path_q : best_path;
        flush_idx    = IDX_W'(pend_q - CNT_W'(1));
        if (run) begin
            flushing_d = 1'b0;
            if (flushing_q) begin
                pend_d = CNT_W'(1);
            end else if (pend_q == CNT_W'(D)) begin
                valid_d = 1'b1;
                x_dec_d = best_path[D-1];
            end else begin
                pend_d = pend_q + CNT_W'(1);
            end
        end else if (pend_q != '0) begin
            if (!flushing_q) flush_path_d = best_path;
            valid_d    = 1'b1;
            x_dec_d    = flush_src[flush_idx];
            pend_d     = pend_q - CNT_W'(1);
            flushing_d = (pend_q != CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NSTATES); i++) begin
                pm_q[i]   <= (i == 0) ? '0 : PM_INIT;
                path_q[i] <= '0;
            end
            pend_q       <= '0;
            flushing_q   <= 1'b0;
            flush_path_q <= '0;
            x_dec_q      <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NSTATES); i++) begin
                pm_q[i]   <= pm_d[i];
                path_q[i] <= path_d[i];
            end
            pend_q       <= pend_d;
            flushing_q   <= flushing_d;
            flush_path_q <= flush_path_d;
            x_dec_q      <= x_dec_d;
            valid_q      <= valid_d;
        end
    end

    assign x_decoded = x_dec_q;
    assign valid     = valid_q;

endmodule

// File: rtl/encoder.sv
// Rate-1/2 K=7 convolutional encoder; coded pair is combinational on x.
module encoder
    import coding_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       x,
    input  logic       run,
    output logic [1:0] x_encoded,
    output logic       valid
);

    logic [SW-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (run) begin
            state_d = {state_q[SW-2:0], x};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign x_encoded = conv_out(x, state_q);
    assign valid     = run;

endmodule

// File: rtl/encoder_decoder.sv
// Channel-coding loopback: convolutional encoder feeding the Viterbi decoder.
module encoder_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       x,
    input  logic       run,
    output logic [1:0] x_encoded,
    output logic       valid_encoder,
    output logic       x_decoded,
    output logic       valid
);

    encoder u_enc (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .run       (run),
        .x_encoded (x_encoded),
        .valid     (valid_encoder)
    );

    decoder u_dec (
        .clk       (clk),
        .rst       (rst),
        .x         (x_encoded),
        .run       (valid_encoder),
        .x_decoded (x_decoded),
        .valid     (valid)
    );

endmodule

// File: tb/tb_encoder_decoder.sv
// Directed/random bench for the encoder/Viterbi loopback, checked against a
// queue-based reference of the code equations and the decoder delivery rules.
module tb_encoder_decoder;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst, x, run;
    logic [1:0] x_encoded;
    logic       valid_encoder, x_decoded, valid;
    logic [1:0] err_sym;
    logic       err_run, err_dec, err_valid;

    encoder_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .x             (x),
        .run           (run),
        .x_encoded     (x_encoded),
        .valid_encoder (valid_encoder),
        .x_decoded     (x_decoded),
        .valid         (valid)
    );

    decoder u_err (
        .clk       (clk),
        .rst       (rst),
        .x         (err_sym),
        .run       (err_run),
        .x_decoded (err_dec),
        .valid     (err_valid)
    );

    always #5 clk = ~clk;

    int   n_vec, n_err, n_out, first_out, cyc;
    bit   hist[$];
    bit   pend[$];
    bit   epend[$];
    bit   in_bits[$];
    bit   dec_bits[$];
    bit   prev_run;
    logic [1:0] last_enc;
    logic [1:0] imp_tbl [7] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Bit k symbols in the past (d1 = previous accepted bit), zero before stream start.
    function automatic bit past(input int k);
        return (hist.size() >= k) ? hist[hist.size() - k] : 1'b0;
    endfunction

    function automatic logic [1:0] ref_pair(input bit xin);
        bit a, b;
        a = xin ^ past(2) ^ past(3) ^ past(5) ^ past(6);
        b = xin ^ past(1) ^ past(2) ^ past(3) ^ past(6);
        return {a, b};
    endfunction

    task automatic do_reset(input bit r, input bit xin);
        rst = 1'b1;
        run = r;
        x   = xin;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b0;
        x   = 1'b0;
        hist.delete();
        pend.delete();
        in_bits.delete();
        dec_bits.delete();
        prev_run  = 1'b0;
        n_out     = 0;
        first_out = -1;
        cyc       = 0;
        check1("rst_valid", valid, 1'b0);
        check1("rst_x_decoded", x_decoded, 1'b0);
        #1;
        check32("rst_x_encoded", 32'(x_encoded), 32'd0);
    endtask

    task automatic step(input bit r, input bit xin);
        logic [1:0] ep;
        bit ev, eb;
        run = r;
        x   = xin;
        #1;
        ep = ref_pair(xin);
        last_enc = x_encoded;
        check32("x_encoded", 32'(x_encoded), 32'(ep));
        check1("valid_encoder", valid_encoder, r);
        ev = 1'b0;
        eb = 1'b0;
        if (r) begin
            if (!prev_run && pend.size() > 0) pend.delete();
            pend.push_back(xin);
            hist.push_back(xin);
            in_bits.push_back(xin);
            if (pend.size() > DEPTH) begin
                ev = 1'b1;
                eb = pend.pop_front();
            end
        end else if (pend.size() > 0) begin
            ev = 1'b1;
            eb = pend.pop_front();
        end
        prev_run = r;
        @(posedge clk);
        #1;
        cyc++;
        check1("valid", valid, ev);
        if (ev) check1("x_decoded", x_decoded, eb);
        if (valid === 1'b1) begin
            n_out++;
            dec_bits.push_back(x_decoded);
            if (first_out < 0) first_out = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        int bad;
        bit b;
        logic [1:0] p;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        run = 1'b0;
        x = 1'b0;
        err_run = 1'b0;
        err_sym = 2'b00;
        @(posedge clk);
        #1;
        do_reset(1'b0, 1'b0);

        // All-zero stream: 68 steady outputs, then 32 flushed.
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0);
        check32("zeros_steady_count", 32'(n_out), 32'd68);
        idle(40);
        check32("zeros_total_count", 32'(n_out), 32'd100);

        // Impulse response of the code.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, (i == 0));
            check32("impulse_pair", 32'(last_enc), 32'(imp_tbl[i]));
        end
        idle(40);
        check32("impulse_count", 32'(n_out), 32'd7);

        // 1000 random bits: latency, count and full-stream equality.
        do_reset(1'b0, 1'b0);
        random_run(1000);
        idle(40);
        check32("rand_count", 32'(n_out), 32'd1000);
        check32("rand_first_valid", 32'(first_out), 32'd33);
        check32("rand_stream_len", 32'(dec_bits.size()), 32'(in_bits.size()));
        bad = 0;
        for (int i = 0; i < dec_bits.size() && i < in_bits.size(); i++) begin
            if (dec_bits[i] != in_bits[i]) bad++;
        end
        check32("rand_stream_bits", 32'(bad), 32'd0);

        // Run gap of 3 cycles: 3 flushed bits, 29 dropped on resume.
        do_reset(1'b0, 1'b0);
        random_run(100);
        idle(3);
        random_run(100);
        idle(40);
        check32("gap_count", 32'(n_out), 32'd171);

        // Reset in the middle of a stream, then a fresh stream.
        do_reset(1'b0, 1'b0);
        random_run(60);
        do_reset(1'b1, 1'b1);
        random_run(100);
        idle(40);
        check32("post_rst_count", 32'(n_out), 32'd100);
        check32("post_rst_first_valid", 32'(first_out), 32'd33);

        // Stand-alone decoder with one flipped coded bit.
        do_reset(1'b0, 1'b0);
        epend.delete();
        n_out = 0;
        for (int i = 0; i < 340; i++) begin
            bit ev, eb;
            ev = 1'b0;
            eb = 1'b0;
            if (i < 300) begin
                b = 1'($urandom_range(0, 1));
                p = ref_pair(b);
                hist.push_back(b);
                if (i == 150) p[1] = ~p[1];
                err_sym = p;
                err_run = 1'b1;
                epend.push_back(b);
                if (epend.size() > DEPTH) begin
                    ev = 1'b1;
                    eb = epend.pop_front();
                end
            end else begin
                err_sym = 2'b00;
                err_run = 1'b0;
                if (epend.size() > 0) begin
                    ev = 1'b1;
                    eb = epend.pop_front();
                end
            end
            @(posedge clk);
            #1;
            check1("err_valid", err_valid, ev);
            if (ev) check1("err_x_decoded", err_dec, eb);
            if (err_valid === 1'b1) n_out++;
        end
        check32("err_count", 32'(n_out), 32'd300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
